// File: rtl/lpc_periph_dispatch_pkg.sv
// Shared types and constants for the LPC peripheral dispatcher.
package lpc_periph_dispatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [7:0] RD_MISS_DATA = 8'hFF;

  // handshake direction as latched from the LPC strobes
  localparam logic DIR_RD = 1'b0;
  localparam logic DIR_WR = 1'b1;

endpackage

// File: rtl/lpc_periph_dispatch_if.sv
// LPC data-provider handshake plus the per-target req/ack bus.
interface lpc_periph_dispatch_if #(parameter int N_TGT = 4);

  logic [15:0]        lpc_addr_i;
  logic               lpc_data_wr;
  logic               lpc_wr_done;
  logic               lpc_data_req;
  logic               lpc_data_rd;
  logic [N_TGT-1:0]   tgt_sel_o;
  logic               tgt_we_o;
  logic [15:0]        tgt_addr_o;
  logic [7:0]         tgt_wdata_o;
  logic [N_TGT*8-1:0] tgt_rdata_i;
  logic [N_TGT-1:0]   tgt_ack_i;

  // dispatcher view
  modport slave (
    input  lpc_addr_i, lpc_data_wr, lpc_data_req, tgt_rdata_i, tgt_ack_i,
    output lpc_wr_done, lpc_data_rd, tgt_sel_o, tgt_we_o, tgt_addr_o, tgt_wdata_o
  );

  // lpc_periph plus register-block view
  modport master (
    output lpc_addr_i, lpc_data_wr, lpc_data_req, tgt_rdata_i, tgt_ack_i,
    input  lpc_wr_done, lpc_data_rd, tgt_sel_o, tgt_we_o, tgt_addr_o, tgt_wdata_o
  );

endinterface

// File: rtl/lpc_periph_dispatch_window_decode.sv
// Combinational address-window match; lowest-index window wins on overlap.
module lpc_periph_dispatch_window_decode #(
  parameter int                  N_TGT    = 4,
  parameter int                  IDX_W    = 2,
  parameter logic [N_TGT*16-1:0] WIN_BASE = 64'hFF00_0060_03F8_0080,
  parameter logic [N_TGT*16-1:0] WIN_MASK = 64'hFF00_FFF0_FFF8_FFFF
) (
  input  logic [15:0]      addr,
  output logic             hit,
  output logic [IDX_W-1:0] idx,
  output logic [15:0]      offset
);

  always_comb begin
    hit    = 1'b0;
    idx    = '0;
    offset = '0;
    // scan downwards so the last assignment is the lowest matching index
    for (int k = N_TGT - 1; k >= 0; k--) begin
      if ((addr & WIN_MASK[k*16 +: 16]) == WIN_BASE[k*16 +: 16]) begin
        hit    = 1'b1;
        idx    = IDX_W'(k);
        offset = addr & ~WIN_MASK[k*16 +: 16];
      end
    end
  end

endmodule

// File: rtl/lpc_periph_dispatch.sv
// Decodes LPC I/O cycles onto N_TGT target windows and runs one req/ack transfer each.
//   state  | meaning
//   IDLE   | waiting for a write or read strobe
//   DECODE | window match being registered
//   ACCESS | target selected, waiting for ack or timeout
//   DONE   | completion shown to lpc_periph until its strobe drops
module lpc_periph_dispatch
  import lpc_periph_dispatch_pkg::*;
#(
  parameter int                  N_TGT    = 4,
  parameter logic [N_TGT*16-1:0] WIN_BASE = 64'hFF00_0060_03F8_0080,
  parameter logic [N_TGT*16-1:0] WIN_MASK = 64'hFF00_FFF0_FFF8_FFFF,
  parameter int                  TIMEOUT  = 64
) (
  input  logic                 LCLK,
  input  logic                 LRESET,
  lpc_periph_dispatch_if.slave bus,
  inout  wire  [7:0]           lpc_data_io,
  output logic                 err_o,
  output logic [7:0]           err_cnt_o
);

  localparam int               IDX_W    = (N_TGT > 1) ? $clog2(N_TGT) : 1;
  localparam int               TMR_W    = $clog2(TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT - 1);

  state_t           state, state_nx;
  logic             wr_q, req_q, strobe;
  logic [15:0]      addr_q, off_q, hit_off;
  logic [7:0]       wdata_q, rdata_q, cnt_q;
  logic             we_q, err_q, hit;
  logic [IDX_W-1:0] idx_q, hit_idx;
  logic [TMR_W-1:0] tmr_q;
  logic             ack_sel, tmr_exp, inc_err, set_err;
  logic             done_wr, done_rd;
  logic [N_TGT-1:0] sel;

  lpc_periph_dispatch_window_decode #(
    .N_TGT    (N_TGT),
    .IDX_W    (IDX_W),
    .WIN_BASE (WIN_BASE),
    .WIN_MASK (WIN_MASK)
  ) u_decode (
    .addr   (addr_q),
    .hit    (hit),
    .idx    (hit_idx),
    .offset (hit_off)
  );

  assign strobe  = wr_q | req_q;
  assign ack_sel = bus.tgt_ack_i[idx_q];
  assign tmr_exp = (tmr_q == '0);

  always_ff @(posedge LCLK or negedge LRESET) begin
    if (!LRESET) state <= ST_IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    inc_err  = 1'b0;
    set_err  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (strobe) begin
          state_nx = ST_DECODE;
          if (wr_q && req_q) begin
            set_err = 1'b1;
            inc_err = 1'b1;
          end
        end
      end
      ST_DECODE: begin
        if (hit) begin
          state_nx = ST_ACCESS;
        end else begin
          state_nx = ST_DONE;
          inc_err  = 1'b1;
        end
      end
      ST_ACCESS: begin
        if (ack_sel) begin
          state_nx = ST_DONE;
        end else if (tmr_exp) begin
          state_nx = ST_DONE;
          set_err  = 1'b1;
          inc_err  = 1'b1;
        end
      end
      ST_DONE: begin
        if (we_q ? !wr_q : !req_q) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge LCLK or negedge LRESET) begin
    if (!LRESET) begin
      wr_q    <= 1'b0;
      req_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= DIR_RD;
      idx_q   <= '0;
      off_q   <= '0;
      tmr_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      wr_q  <= bus.lpc_data_wr;
      req_q <= bus.lpc_data_req;
      case (state)
        ST_IDLE: begin
          if (strobe) begin
            addr_q  <= bus.lpc_addr_i;
            wdata_q <= lpc_data_io;
            we_q    <= wr_q ? DIR_WR : DIR_RD;
          end
        end
        ST_DECODE: begin
          idx_q <= hit_idx;
          off_q <= hit_off;
          tmr_q <= TMR_LOAD;
          if (!hit) rdata_q <= RD_MISS_DATA;
        end
        ST_ACCESS: begin
          if (ack_sel)      rdata_q <= bus.tgt_rdata_i[{idx_q, 3'b000} +: 8];
          else if (tmr_exp) rdata_q <= RD_MISS_DATA;
          else              tmr_q   <= tmr_q - 1'b1;
        end
        default: ;
      endcase
      err_q <= err_q | set_err;
      if (inc_err && (cnt_q != 8'hFF)) cnt_q <= cnt_q + 8'd1;
    end
  end

  always_comb begin
    sel = '0;
    if (state == ST_ACCESS) sel[idx_q] = 1'b1;
  end

  assign done_wr = (state == ST_DONE) && we_q;
  assign done_rd = (state == ST_DONE) && !we_q;

  assign bus.tgt_sel_o   = sel;
  assign bus.tgt_we_o    = (state == ST_ACCESS) && we_q;
  assign bus.tgt_addr_o  = off_q;
  assign bus.tgt_wdata_o = wdata_q;
  assign bus.lpc_wr_done = done_wr;
  assign bus.lpc_data_rd = done_rd;
  assign lpc_data_io     = done_rd ? rdata_q : 8'bz;
  assign err_o           = err_q;
  assign err_cnt_o       = cnt_q;

endmodule

// File: tb/tb_lpc_periph_dispatch.sv
// Scoreboard bench: stimulus queues expected completions, a monitor checks each one.
module tb_lpc_periph_dispatch;

  logic       LCLK = 1'b0;
  logic       LRESET = 1'b0;
  logic       tb_drv = 1'b0;
  logic [7:0] tb_wdata = 8'h00;
  logic       err_o;
  logic [7:0] err_cnt_o;
  wire  [7:0] lpc_data_io;

  lpc_periph_dispatch_if #(.N_TGT(4)) bus();

  assign lpc_data_io = tb_drv ? tb_wdata : 8'bz;

  lpc_periph_dispatch #(.N_TGT(4), .TIMEOUT(64)) dut (
    .LCLK        (LCLK),
    .LRESET      (LRESET),
    .bus         (bus),
    .lpc_data_io (lpc_data_io),
    .err_o       (err_o),
    .err_cnt_o   (err_cnt_o)
  );

  always #5 LCLK = ~LCLK;

  int cyc = 0;
  always @(posedge LCLK) cyc = cyc + 1;

  // target register blocks: each acks dly[k]+1 cycles into its select
  int         dly [4];
  logic [7:0] rdv [4];
  bit         spurious = 1'b0;
  int         seen = 0;

  always_comb bus.tgt_rdata_i = {rdv[3], rdv[2], rdv[1], rdv[0]};

  always @(negedge LCLK) begin
    bus.tgt_ack_i = 4'b0000;
    if (bus.tgt_sel_o != 4'b0000) begin
      seen = seen + 1;
      for (int k = 0; k < 4; k++)
        if (bus.tgt_sel_o[k] && seen == dly[k] + 1) bus.tgt_ack_i[k] = 1'b1;
      if (spurious && seen == 1) bus.tgt_ack_i = bus.tgt_ack_i | ~bus.tgt_sel_o;
    end else begin
      seen = 0;
    end
  end

  typedef struct {
    string       name;
    logic [3:0]  sel;
    logic        we;
    logic [15:0] off;
    logic [7:0]  data;
    logic        err;
    logic [7:0]  cnt;
    int          lat;
    int          sel_cyc;
    int          start;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string nm, input string what, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s.%s: got 0x%0h, expected 0x%0h", nm, what, act, req);
    end
  endtask

  task automatic flag(input string nm, input string what);
    n_tests++;
    n_fail++;
    $display("FAIL %s.%s: event missing or unexpected", nm, what);
  endtask

  // monitor
  logic [3:0]  o_sel = 4'b0000;
  logic        o_we = 1'b0;
  logic [15:0] o_off = 16'h0000;
  logic [7:0]  o_wd = 8'h00;
  int          o_at = 0;
  int          o_cyc = 0;
  bit          o_unstable = 1'b0;
  bit          prev = 1'b0;
  exp_t        me;

  always @(negedge LCLK) begin
    if (!LRESET) begin
      o_sel = 4'b0000; o_cyc = 0; o_unstable = 1'b0; prev = 1'b0;
    end else begin
      if (bus.tgt_sel_o != 4'b0000) begin
        if (o_cyc == 0) begin
          o_sel = bus.tgt_sel_o; o_we = bus.tgt_we_o;
          o_off = bus.tgt_addr_o; o_wd = bus.tgt_wdata_o; o_at = cyc;
        end else if ({bus.tgt_sel_o, bus.tgt_we_o, bus.tgt_addr_o, bus.tgt_wdata_o}
                     != {o_sel, o_we, o_off, o_wd}) begin
          o_unstable = 1'b1;
        end
        o_cyc = o_cyc + 1;
      end
      if ((bus.lpc_wr_done || bus.lpc_data_rd) && !prev) begin
        if (exp_q.size() == 0) begin
          flag("monitor", "unexpected_done");
        end else begin
          me = exp_q.pop_front();
          chk(me.name, "sel",      32'(o_sel), 32'(me.sel));
          chk(me.name, "dir",      32'(bus.lpc_wr_done), 32'(me.we));
          chk(me.name, "done_lat", cyc - me.start, me.lat);
          chk(me.name, "err_o",    32'(err_o), 32'(me.err));
          chk(me.name, "err_cnt",  32'(err_cnt_o), 32'(me.cnt));
          if (me.sel != 4'b0000) begin
            chk(me.name, "we",         32'(o_we), 32'(me.we));
            chk(me.name, "offset",     32'(o_off), 32'(me.off));
            chk(me.name, "sel_lat",    o_at - me.start, 2);
            chk(me.name, "sel_cycles", o_cyc, me.sel_cyc);
            chk(me.name, "stable",     32'(o_unstable), 0);
          end
          if (me.we) begin
            if (me.sel != 4'b0000) chk(me.name, "wdata", 32'(o_wd), 32'(me.data));
          end else begin
            chk(me.name, "rdata", 32'(lpc_data_io), 32'(me.data));
          end
        end
        o_sel = 4'b0000; o_cyc = 0; o_unstable = 1'b0;
      end
      prev = bus.lpc_wr_done || bus.lpc_data_rd;
    end
  end

  // reference model of the sticky error flag and saturating counter
  logic       m_err = 1'b0;
  logic [7:0] m_cnt = 8'h00;

  task automatic bump();
    if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
  endtask

  task automatic xfer(input string nm, input logic [15:0] a, input bit wr, input bit rq,
                      input logic [7:0] wd, input logic [3:0] sel, input logic [15:0] off,
                      input logic [7:0] data, input int dsel);
    exp_t e;
    bit   got, to;
    to = (sel != 4'b0000) && (dsel >= 64);
    if (wr && rq) begin m_err = 1'b1; bump(); end
    if (sel == 4'b0000 || to) bump();
    if (to) m_err = 1'b1;
    e.name = nm; e.sel = sel; e.we = wr; e.off = off; e.data = data;
    e.err = m_err; e.cnt = m_cnt;
    e.lat = (sel == 4'b0000) ? 2 : (to ? 66 : 3 + dsel);
    e.sel_cyc = to ? 64 : dsel + 1;
    @(negedge LCLK);
    e.start = cyc + 1;
    exp_q.push_back(e);
    bus.lpc_addr_i = a; tb_wdata = wd; tb_drv = wr;
    bus.lpc_data_wr = wr; bus.lpc_data_req = rq;
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge LCLK);
      if (bus.lpc_wr_done || bus.lpc_data_rd) begin got = 1'b1; break; end
    end
    if (!got) flag(nm, "no_completion");
    bus.lpc_data_wr = 1'b0; bus.lpc_data_req = 1'b0; tb_drv = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge LCLK);
      if (!(bus.lpc_wr_done || bus.lpc_data_rd)) break;
    end
    chk(nm, "release", 32'(bus.lpc_wr_done || bus.lpc_data_rd), 0);
  endtask

  initial begin
    bit got;
    bus.lpc_addr_i = 16'h0000; bus.lpc_data_wr = 1'b0; bus.lpc_data_req = 1'b0;
    for (int k = 0; k < 4; k++) begin dly[k] = 0; rdv[k] = 8'h00; end
    repeat (3) @(negedge LCLK);
    chk("reset", "sel",     32'(bus.tgt_sel_o), 0);
    chk("reset", "wr_done", 32'(bus.lpc_wr_done), 0);
    chk("reset", "rd",      32'(bus.lpc_data_rd), 0);
    chk("reset", "err_o",   32'(err_o), 0);
    chk("reset", "err_cnt", 32'(err_cnt_o), 0);
    #2 LRESET = 1'b1;
    @(negedge LCLK);

    dly[0] = 0;
    xfer("wr0080", 16'h0080, 1'b1, 1'b0, 8'h3C, 4'b0001, 16'h0000, 8'h3C, 0);

    dly[1] = 9; rdv[1] = 8'hA5; rdv[0] = 8'h11; spurious = 1'b1;
    xfer("rd03FD", 16'h03FD, 1'b0, 1'b1, 8'h00, 4'b0010, 16'h0005, 8'hA5, 9);
    spurious = 1'b0;

    xfer("rd_miss", 16'h1234, 1'b0, 1'b1, 8'h00, 4'b0000, 16'h0000, 8'hFF, 0);

    dly[3] = 255;
    xfer("wr_timeout", 16'hFF10, 1'b1, 1'b0, 8'h77, 4'b1000, 16'h0010, 8'h77, 255);

    // reset while tgt2 is selected
    dly[2] = 255;
    @(negedge LCLK);
    bus.lpc_addr_i = 16'h0060; bus.lpc_data_req = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge LCLK);
      if (bus.tgt_sel_o != 4'b0000) begin got = 1'b1; break; end
    end
    if (!got) flag("rst_access", "no_select");
    chk("rst_access", "sel_before", 32'(bus.tgt_sel_o), 32'h4);
    repeat (3) @(negedge LCLK);
    #2 LRESET = 1'b0;
    #1;
    chk("rst_access", "sel",     32'(bus.tgt_sel_o), 0);
    chk("rst_access", "wr_done", 32'(bus.lpc_wr_done), 0);
    chk("rst_access", "rd",      32'(bus.lpc_data_rd), 0);
    chk("rst_access", "err_o",   32'(err_o), 0);
    chk("rst_access", "err_cnt", 32'(err_cnt_o), 0);
    bus.lpc_data_req = 1'b0;
    m_err = 1'b0; m_cnt = 8'h00;
    @(negedge LCLK);
    #2 LRESET = 1'b1;

    dly[0] = 0; rdv[0] = 8'h5A;
    xfer("rd_after_rst", 16'h0080, 1'b0, 1'b1, 8'h00, 4'b0001, 16'h0000, 8'h5A, 0);

    dly[2] = 1;
    xfer("wr_rd_both", 16'h0060, 1'b1, 1'b1, 8'hC3, 4'b0100, 16'h0000, 8'hC3, 1);

    dly[2] = 2; rdv[2] = 8'h96;
    xfer("rd006B", 16'h006B, 1'b0, 1'b1, 8'h00, 4'b0100, 16'h000B, 8'h96, 2);

    for (int i = 0; i < 256; i++)
      xfer("miss_sat", 16'h2000, 1'b0, 1'b1, 8'h00, 4'b0000, 16'h0000, 8'hFF, 0);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge LCLK);
    if (exp_q.size() != 0) flag("scoreboard", "pending_expectations");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
